ascon_decrypt_core: RTL and testbench

Iterative Ascon-128 decryption engine: the receiving-side counterpart of the encryption permutation/XOR datapath. It consumes a key, nonce, associated-data blocks and 64-bit ciphertext blocks, and emits plaintext blocks. It then computes the tag and compares it against the expected tag. It sits between the ciphertext ingress interface and the plaintext consumer, and reuses the codebase's Pc/Ps/Pl round layers.

---
 rtl/ascon_pack.sv | 32 +++
 rtl/ascon_round_comb.sv | 41 ++++
 rtl/ascon_decrypt_core.sv | 157 +++++++++++++++
 tb/tb_ascon_decrypt_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon decryption types and constants.
// ASCON_DEC_DOUBLE_ROUND_EN selects two cascaded rounds per clock instead of one.
package ascon_pack;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  localparam logic [63:0] ASCON_IV  = 64'h80400C0600000000;
  localparam logic [63:0] ASCON_PAD = 64'h8000000000000000;

`ifdef ASCON_DEC_DOUBLE_ROUND_EN
  localparam logic [3:0] R_STEP = 4'd2;
`else
  localparam logic [3:0] R_STEP = 4'd1;
`endif
  // Counter value of the cycle that executes round 11.
  localparam logic [3:0] R_LAST = 4'd12 - R_STEP;

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD_PERM, WAIT_CT, CT_PERM, FINAL, DONE
  } state_e;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round_comb.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
module ascon_round_comb
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  logic [7:0]  rc;
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;
  logic [63:0] s0, s1, s2, s3, s4;

  assign rc = {4'hF - round_i, round_i};

  assign a0 = state_i.x0 ^ state_i.x4;
  assign a1 = state_i.x1;
  assign a2 = state_i.x2 ^ {56'h0, rc} ^ state_i.x1;
  assign a3 = state_i.x3;
  assign a4 = state_i.x4 ^ state_i.x3;

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign s0 = b0 ^ b4;
  assign s1 = b1 ^ b0;
  assign s2 = ~b2;
  assign s3 = b3 ^ b2;
  assign s4 = b4;

  assign state_o.x0 = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
  assign state_o.x1 = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
  assign state_o.x2 = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
  assign state_o.x3 = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
  assign state_o.x4 = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);

endmodule

// File: rtl/ascon_decrypt_core.sv
// Iterative Ascon-128 decryption: releases plaintext per block, then checks the tag.
// ASCON_DEC_DOUBLE_ROUND_EN cascades two round instances so r advances by 2 per clock.
module ascon_decrypt_core
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         noad_i,
  input  logic [127:0] key_i,
  input  logic [127:0] nonce_i,
  input  logic [127:0] tag_i,
  input  logic [63:0]  ad_i,
  input  logic         ad_valid_i,
  input  logic         ad_last_i,
  output logic         ad_ready_o,
  input  logic [63:0]  ct_i,
  input  logic         ct_valid_i,
  input  logic         ct_last_i,
  output logic         ct_ready_o,
  output logic [63:0]  pt_o,
  output logic         pt_valid_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         tag_ok_o
);

  state_e        state_q, state_d;
  type_state     st_q, st_d, rnd_out;
  logic [3:0]    r_q, r_d;
  logic [127:0]  key_q, key_d, tag_q, tag_d;
  logic          noad_q, noad_d, last_q, last_d;
  logic [63:0]   pt_q, pt_d;
  logic          pt_valid_q, pt_valid_d, tag_ok_q, tag_ok_d;
  logic          round_last, tag_match;

`ifdef ASCON_DEC_DOUBLE_ROUND_EN
  type_state rnd_mid;
  ascon_round_comb u_round0 (.state_i(st_q),    .round_i(r_q),        .state_o(rnd_mid));
  ascon_round_comb u_round1 (.state_i(rnd_mid), .round_i(r_q + 4'd1), .state_o(rnd_out));
`else
  ascon_round_comb u_round0 (.state_i(st_q), .round_i(r_q), .state_o(rnd_out));
`endif

  assign round_last = (r_q == R_LAST);
  assign tag_match  = ({st_q.x3 ^ key_q[127:64], st_q.x4 ^ key_q[63:0]} == tag_q);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)    state_d = INIT;
      INIT:    if (round_last) state_d = noad_q ? WAIT_CT : WAIT_AD;
      WAIT_AD: if (ad_valid_i) state_d = AD_PERM;
      AD_PERM: if (round_last) state_d = last_q ? WAIT_CT : WAIT_AD;
      WAIT_CT: if (ct_valid_i) state_d = CT_PERM;
      CT_PERM: if (round_last) state_d = last_q ? FINAL : WAIT_CT;
      FINAL:   if (round_last) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // tag_ok_o is valid alongside done_o and then held from the registered copy.
  always_comb begin
    ad_ready_o = (state_q == WAIT_AD);
    ct_ready_o = (state_q == WAIT_CT);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    tag_ok_o   = (state_q == DONE) ? tag_match : tag_ok_q;
  end

  always_comb begin
    st_d       = st_q;
    r_d        = r_q;
    key_d      = key_q;
    tag_d      = tag_q;
    noad_d     = noad_q;
    last_d     = last_q;
    pt_d       = pt_q;
    pt_valid_d = 1'b0;
    tag_ok_d   = tag_ok_q;
    case (state_q)
      IDLE: if (start_i) begin
        st_d     = '{ASCON_IV, key_i[127:64], key_i[63:0], nonce_i[127:64], nonce_i[63:0]};
        key_d    = key_i;
        tag_d    = tag_i;
        noad_d   = noad_i;
        r_d      = 4'd0;
        tag_ok_d = 1'b0;
      end
      INIT, AD_PERM, CT_PERM, FINAL: begin
        st_d = rnd_out;
        r_d  = r_q + R_STEP;
        if (round_last) begin
          r_d = 4'd0;
          if (state_q == INIT) begin
            st_d.x3 = rnd_out.x3 ^ key_q[127:64];
            st_d.x4 = rnd_out.x4 ^ key_q[63:0] ^ {63'h0, noad_q};
          end else if (state_q == AD_PERM) begin
            st_d.x4 = rnd_out.x4 ^ {63'h0, last_q};
          end else if (state_q == CT_PERM && last_q) begin
            st_d.x0 = rnd_out.x0 ^ ASCON_PAD;
            st_d.x1 = rnd_out.x1 ^ key_q[127:64];
            st_d.x2 = rnd_out.x2 ^ key_q[63:0];
          end
        end
      end
      WAIT_AD: if (ad_valid_i) begin
        st_d.x0 = st_q.x0 ^ ad_i;
        last_d  = ad_last_i;
        r_d     = 4'd6;
      end
      WAIT_CT: if (ct_valid_i) begin
        pt_d       = st_q.x0 ^ ct_i;
        pt_valid_d = 1'b1;
        st_d.x0    = ct_i;
        last_d     = ct_last_i;
        r_d        = 4'd6;
      end
      DONE: tag_ok_d = tag_match;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      st_q       <= '0;
      r_q        <= '0;
      key_q      <= '0;
      tag_q      <= '0;
      noad_q     <= 1'b0;
      last_q     <= 1'b0;
      pt_q       <= '0;
      pt_valid_q <= 1'b0;
      tag_ok_q   <= 1'b0;
    end else begin
      st_q       <= st_d;
      r_q        <= r_d;
      key_q      <= key_d;
      tag_q      <= tag_d;
      noad_q     <= noad_d;
      last_q     <= last_d;
      pt_q       <= pt_d;
      pt_valid_q <= pt_valid_d;
      tag_ok_q   <= tag_ok_d;
    end
  end

  assign pt_o       = pt_q;
  assign pt_valid_o = pt_valid_q;

endmodule

// File: tb/tb_ascon_decrypt_core.sv
// Self-checking bench: messages are encrypted by a reference Ascon-128 model, then decrypted by the core.
module tb_ascon_decrypt_core;

`ifdef ASCON_DEC_DOUBLE_ROUND_EN
  localparam int INIT_C = 6;
  localparam int PERM_C = 3;
`else
  localparam int INIT_C = 12;
  localparam int PERM_C = 6;
`endif
  localparam int FIN_C = INIT_C;

  logic         clock_i = 1'b0;
  logic         resetb_i, start_i, noad_i;
  logic [127:0] key_i, nonce_i, tag_i;
  logic [63:0]  ad_i, ct_i, pt_o;
  logic         ad_valid_i, ad_last_i, ad_ready_o;
  logic         ct_valid_i, ct_last_i, ct_ready_o;
  logic         pt_valid_o, busy_o, done_o, tag_ok_o;

  ascon_decrypt_core dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .noad_i(noad_i),
    .key_i(key_i), .nonce_i(nonce_i), .tag_i(tag_i),
    .ad_i(ad_i), .ad_valid_i(ad_valid_i), .ad_last_i(ad_last_i), .ad_ready_o(ad_ready_o),
    .ct_i(ct_i), .ct_valid_i(ct_valid_i), .ct_last_i(ct_last_i), .ct_ready_o(ct_ready_o),
    .pt_o(pt_o), .pt_valid_o(pt_valid_o), .busy_o(busy_o), .done_o(done_o), .tag_ok_o(tag_ok_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model data for the current message.
  logic [63:0]  ad_mem [4];
  logic [63:0]  pt_mem [4];
  logic [63:0]  ct_mem [4];
  int           nad, nct;
  logic [127:0] m_key, m_nonce, m_tag;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s_in, input int first);
    logic [63:0]  x [5];
    logic [63:0]  t [5];
    logic [319:0] s_out;
    for (int i = 0; i < 5; i++) x[i] = s_in[319-64*i -: 64];
    for (int r = first; r < 12; r++) begin
      x[2] ^= 64'((15 - r) * 16 + r);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] ^= rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] ^= rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    for (int i = 0; i < 5; i++) s_out[319-64*i -: 64] = x[i];
    return s_out;
  endfunction

  // Ascon-128 encryption of full plaintext blocks; x0 is the top word of s.
  task automatic model_encrypt();
    logic [319:0] s;
    s = {64'h80400C0600000000, m_key, m_nonce};
    s = perm(s, 0);
    s[127:0] ^= m_key;
    for (int i = 0; i < nad; i++) begin
      s[319:256] ^= ad_mem[i];
      s = perm(s, 6);
    end
    s[0] ^= 1'b1;
    for (int i = 0; i < nct; i++) begin
      s[319:256] ^= pt_mem[i];
      ct_mem[i] = s[319:256];
      s = perm(s, 6);
    end
    s[319:256] ^= 64'h8000000000000000;
    s[255:128] ^= m_key;
    s = perm(s, 0);
    m_tag = s[127:0] ^ m_key;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Cycle k counts clocks after the edge that accepts start (that edge is cycle 0).
  task automatic run_msg(input string nm, input bit flip, input int stall_blk, input bit gaps,
                         input bit noise, input int abort_at, input bit chk_lat);
    int k, ai, ci, pi, first_ad, first_ct, done_k, stall_left, stall_ok;
    bit done_seen, any_done, withhold;
    @(negedge clock_i);
    key_i = m_key; nonce_i = m_nonce; tag_i = m_tag ^ {127'h0, flip};
    noad_i = (nad == 0); start_i = 1'b1; ad_valid_i = 1'b0; ct_valid_i = 1'b0;
    @(posedge clock_i);
    k = 0; ai = 0; ci = 0; pi = 0; first_ad = -1; first_ct = -1; done_k = -1;
    stall_left = 20; stall_ok = 0; done_seen = 0;
    while (!done_seen && k < 3000) begin
      @(negedge clock_i);
      k++;
      if (k == abort_at) begin
        resetb_i = 1'b0;
        #1;
        check_eq({nm, "_rst_outs"},
                 128'({pt_o, ad_ready_o, ct_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o}), 128'(0));
        #2;
        resetb_i = 1'b1; start_i = 1'b0; ad_valid_i = 1'b0; ct_valid_i = 1'b0;
        any_done = 0;
        repeat (40) begin
          @(negedge clock_i);
          any_done |= done_o;
        end
        check_eq({nm, "_no_done"}, 128'(any_done), 128'(0));
        return;
      end
      if (k == 1) check_eq({nm, "_busy"}, 128'(busy_o), 128'(1));
      if (ad_ready_o && first_ad < 0) first_ad = k;
      if (ct_ready_o && first_ct < 0) first_ct = k;
      if (pt_valid_o) begin
        if (pi < nct) check_eq({nm, "_pt"}, 128'(pt_o), 128'(pt_mem[pi]));
        pi++;
      end
      if (done_o) begin
        done_seen = 1;
        done_k = k;
        check_eq({nm, "_tag_ok"}, 128'(tag_ok_o), 128'(!flip));
      end else begin
        start_i = noise ? 1'($urandom % 2) : 1'b0;
        if (noise) begin key_i = {rnd64(), rnd64()}; tag_i = {rnd64(), rnd64()}; end
        if (ai < nad && !(gaps && $urandom % 3 == 0)) begin
          ad_valid_i = 1'b1; ad_i = ad_mem[ai]; ad_last_i = (ai == nad - 1);
        end else begin
          ad_valid_i = (ai >= nad && noise) ? 1'($urandom % 2) : 1'b0;
          ad_i = rnd64(); ad_last_i = 1'($urandom % 2);
        end
        if (ad_valid_i && ad_ready_o) ai++;
        withhold = (ci == stall_blk) && (stall_left > 0) && (ct_ready_o || stall_left < 20);
        if (withhold) begin
          stall_left--;
          if (ct_ready_o && !pt_valid_o && busy_o && !done_o) stall_ok++;
        end
        if (ci < nct && !withhold && !(gaps && $urandom % 3 == 0)) begin
          ct_valid_i = 1'b1; ct_i = ct_mem[ci]; ct_last_i = (ci == nct - 1);
        end else begin
          ct_valid_i = (ci >= nct && noise) ? 1'($urandom % 2) : 1'b0;
          ct_i = rnd64(); ct_last_i = 1'($urandom % 2);
        end
        if (ct_valid_i && ct_ready_o) ci++;
      end
    end
    start_i = 1'b0; ad_valid_i = 1'b0; ct_valid_i = 1'b0;
    check_eq({nm, "_done_seen"}, 128'(done_seen), 128'(1));
    if (done_seen) begin
      check_eq({nm, "_pt_count"}, 128'(pi), 128'(nct));
      if (chk_lat) begin
        check_eq({nm, "_done_cycle"}, 128'(done_k),
                 128'(INIT_C + (nad + nct) * (1 + PERM_C) + FIN_C + 1));
        if (nad > 0) begin
          check_eq({nm, "_first_ad_ready"}, 128'(first_ad), 128'(INIT_C + 1));
        end else begin
          check_eq({nm, "_ad_ready_never"}, 128'(first_ad), 128'(-1));
          check_eq({nm, "_first_ct_ready"}, 128'(first_ct), 128'(INIT_C + 1));
        end
      end
      if (stall_blk >= 0) check_eq({nm, "_stall_stable"}, 128'(stall_ok), 128'(20));
      @(negedge clock_i);
      check_eq({nm, "_tag_ok_held"}, 128'(tag_ok_o), 128'(!flip));
      check_eq({nm, "_idle"}, 128'({busy_o, done_o, pt_valid_o}), 128'(0));
    end
  endtask

  logic [63:0] kat_ad, kat_pt0, kat_pt1;

  task automatic load_kat();
    m_key = 128'h000102030405060708090A0B0C0D0E0F;
    m_nonce = 128'h000102030405060708090A0B0C0D0E0F;
    nad = 1; nct = 2;
    ad_mem[0] = kat_ad; pt_mem[0] = kat_pt0; pt_mem[1] = kat_pt1;
    model_encrypt();
  endtask

  initial begin
    resetb_i = 1'b0; start_i = 1'b0; noad_i = 1'b0;
    key_i = '0; nonce_i = '0; tag_i = '0; ad_i = '0; ct_i = '0;
    ad_valid_i = 1'b0; ad_last_i = 1'b0; ct_valid_i = 1'b0; ct_last_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check_eq("reset_outs",
             128'({pt_o, ad_ready_o, ct_ready_o, pt_valid_o, busy_o, done_o, tag_ok_o}), 128'(0));
    resetb_i = 1'b1;
    @(negedge clock_i);
    check_eq("idle_after_reset", 128'({busy_o, done_o}), 128'(0));

    kat_ad = rnd64(); kat_pt0 = rnd64(); kat_pt1 = rnd64();
    load_kat();
    run_msg("kat", 1'b0, -1, 1'b0, 1'b0, 0, 1'b1);
    run_msg("kat_badtag", 1'b1, -1, 1'b0, 1'b0, 0, 1'b1);
    run_msg("kat_stall", 1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
    run_msg("kat_abort", 1'b0, -1, 1'b0, 1'b0,
            INIT_C + 3 * (1 + PERM_C) + 3, 1'b0);
    run_msg("kat_after_rst", 1'b0, -1, 1'b0, 1'b0, 0, 1'b1);

    m_key = {rnd64(), rnd64()}; m_nonce = {rnd64(), rnd64()};
    nad = 0; nct = 1; pt_mem[0] = rnd64();
    model_encrypt();
    run_msg("noad", 1'b0, -1, 1'b0, 1'b0, 0, 1'b1);

    for (int m = 0; m < 8; m++) begin
      m_key = {rnd64(), rnd64()}; m_nonce = {rnd64(), rnd64()};
      nad = $urandom_range(0, 3); nct = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin ad_mem[i] = rnd64(); pt_mem[i] = rnd64(); end
      model_encrypt();
      run_msg("rand", 1'($urandom % 2), -1, 1'b1, 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
